// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles 32-bit key/data words into 128-bit blocks and sequences the AES core
module aes_block_loader #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_key,
    input  logic         s_cipher,
    output logic         start,
    output logic [127:0] din,
    output logic [127:0] key_in,
    output logic         cipher,
    input  logic         finish,
    output logic         busy,
    output logic         key_valid,
    output logic         timeout_err
);
    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] FIRE = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    logic [1:0]    state_q, state_d;
    logic [95:0]   key_sh_q, key_sh_d;
    logic [95:0]   data_sh_q, data_sh_d;
    logic [1:0]    key_cnt_q, key_cnt_d;
    logic [1:0]    data_cnt_q, data_cnt_d;
    logic [127:0]  key_in_q, key_in_d;
    logic [127:0]  din_q, din_d;
    logic          cipher_q, cipher_d;
    logic          key_valid_q, key_valid_d;
    logic          timeout_err_q, timeout_err_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          acc;
    assign s_ready     = (state_q == FILL) && (s_key || key_valid_q) && !arst;
    assign acc         = s_valid && s_ready;
    assign start       = state_q == FIRE;
    assign busy        = (state_q == FIRE) || (state_q == WAIT);
    assign din         = din_q;
    assign key_in      = key_in_q;
    assign cipher      = cipher_q;
    assign key_valid   = key_valid_q;
    assign timeout_err = timeout_err_q;
    // Word assembly in FILL, one-cycle start in FIRE, finish/timeout wait in WAIT
    always_comb begin
        state_d       = state_q;
        key_sh_d      = key_sh_q;
        data_sh_d     = data_sh_q;
        key_cnt_d     = key_cnt_q;
        data_cnt_d    = data_cnt_q;
        key_in_d      = key_in_q;
        din_d         = din_q;
        cipher_d      = cipher_q;
        key_valid_d   = key_valid_q;
        timeout_err_d = timeout_err_q;
        tcnt_d        = tcnt_q;
        if (state_q == FILL) begin
            if (acc && s_key) begin
                key_sh_d  = {key_sh_q[63:0], s_data};
                key_cnt_d = key_cnt_q + 2'd1;
                if (key_cnt_q == 2'd3) begin
                    key_in_d    = {key_sh_q, s_data};
                    key_valid_d = 1'b1;
                end
            end
            if (acc && !s_key) begin
                data_sh_d  = {data_sh_q[63:0], s_data};
                data_cnt_d = data_cnt_q + 2'd1;
                if (data_cnt_q == 2'd3) begin
                    din_d    = {data_sh_q, s_data};
                    cipher_d = s_cipher;
                    state_d  = FIRE;
                end
            end
        end else if (state_q == FIRE) begin
            state_d = WAIT;
            tcnt_d  = '0;
        end else if (state_q == WAIT) begin
            if (finish) begin
                state_d = FILL;
            end else if (TIMEOUT_CYCLES != 0 && tcnt_q == T_LAST) begin
                timeout_err_d = 1'b1;
                state_d       = FILL;
            end else if (tcnt_q != {TW{1'b1}}) begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end else begin
            state_d = FILL;
        end
    end
    // State registers with synchronous clear of everything, including partial shadows
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q       <= FILL;
            key_sh_q      <= '0;
            data_sh_q     <= '0;
            key_cnt_q     <= '0;
            data_cnt_q    <= '0;
            key_in_q      <= '0;
            din_q         <= '0;
            cipher_q      <= 1'b0;
            key_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            key_sh_q      <= key_sh_d;
            data_sh_q     <= data_sh_d;
            key_cnt_q     <= key_cnt_d;
            data_cnt_q    <= data_cnt_d;
            key_in_q      <= key_in_d;
            din_q         <= din_d;
            cipher_q      <= cipher_d;
            key_valid_q   <= key_valid_d;
            timeout_err_q <= timeout_err_d;
            tcnt_q        <= tcnt_d;
        end
    end
endmodule
